// File: rtl/exec_sequencer.sv
// exec_sequencer: single-issue execute controller sitting between decode,
// reg_file and alu. One op in flight: IDLE -> READ -> EXEC -> WB -> RESP.
// Optional feature macro: DIV_ZERO_GUARD_EN (divide/remainder-by-zero
// override of the alu result, flagged on rsp_err).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. valid, once raised, holds with its payload stable until that
// edge; ready may be asserted independently of valid.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 READ, 2 EXEC, 3 WB, 4 RESP).
module exec_sequencer #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              req_use_imm,
  input  logic [DATA_W-1:0] req_imm,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_rs1_val,
  input  logic [DATA_W-1:0] rf_rs2_val,
  output logic              rf_write_sig,
  output logic [DATA_W-1:0] rf_write_val,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_value1,
  output logic [DATA_W-1:0] alu_value2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [DATA_W-1:0] rsp_value,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  ops_retired,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] wb_result;
  logic              wb_err;
  logic [REG_AW-1:0] rsp_rd_q;
  logic [DATA_W-1:0] rsp_value_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  retired_q;

  // State register; reset drops any in-flight op immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed one-cycle steps except RESP, which waits for rsp_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request on acceptance; register indices drive reg_file directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      rf_rs1    <= '0;
      rf_rs2    <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      op_q      <= req_opcode;
      rf_rs1    <= req_rs1;
      rf_rs2    <= req_rs2;
      rd_q      <= req_rd;
      use_imm_q <= req_use_imm;
      imm_q     <= req_imm;
    end
  end

  assign alu_opcode = op_q;

  // ALU operands only during EXEC. rf_rs*_val come straight off the
  // reg_file's output register, so this is a register-to-alu path.
  always_comb begin
    alu_value1 = '0;
    alu_value2 = '0;
    if (state_q == S_EXEC) begin
      alu_value1 = rf_rs1_val;
      alu_value2 = use_imm_q ? imm_q : rf_rs2_val;
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_REM = OP_W'(7);

  logic [DATA_W-1:0] v1_q;
  logic [DATA_W-1:0] v2_q;

  // Keep the operands seen by the alu so WB can detect a zero divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= '0;
      v2_q <= '0;
    end else if (state_q == S_EXEC) begin
      v1_q <= alu_value1;
      v2_q <= alu_value2;
    end
  end

  // Zero-divisor override: DIV gives all-ones, REM gives the dividend.
  always_comb begin
    wb_result = alu_result;
    wb_err    = 1'b0;
    if (op_q == OP_DIV && v2_q == '0) begin
      wb_result = '1;
      wb_err    = 1'b1;
    end else if (op_q == OP_REM && v2_q == '0) begin
      wb_result = v1_q;
      wb_err    = 1'b1;
    end
  end
`else
  // No override: alu result passes through and no error is ever raised.
  always_comb begin
    wb_result = alu_result;
    wb_err    = 1'b0;
  end
`endif

  // Writeback strobe exists only in WB; rd 0 is never written.
  always_comb begin
    rf_write_sig = 1'b0;
    rf_write_val = '0;
    rf_write_reg = '0;
    if (state_q == S_WB) begin
      rf_write_sig = (rd_q != '0);
      rf_write_val = wb_result;
      rf_write_reg = rd_q;
    end
  end

  // Response payload loads in WB and stays put through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rd_q    <= '0;
      rsp_value_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == S_WB) begin
      rsp_rd_q    <= rd_q;
      rsp_value_q <= wb_result;
      rsp_err_q   <= wb_err;
    end
  end

  // Retired-op counter steps on each response handshake and wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                retired_q <= '0;
    else if (state_q == S_RESP && rsp_ready) retired_q <= retired_q + 1'b1;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rd      = rsp_rd_q;
  assign rsp_value   = rsp_value_q;
  assign rsp_err     = rsp_err_q;
  assign ops_retired = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed bench for exec_sequencer with a behavioural
// reg_file/alu environment and a reference register-file model.
// Build with +define+DIV_ZERO_GUARD_EN to check the guarded variant.
module tb_exec_sequencer;
  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int OP_W   = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [OP_W-1:0]   req_opcode = '0;
  logic [REG_AW-1:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic              req_use_imm = 1'b0;
  logic [DATA_W-1:0] req_imm = '0;
  logic [REG_AW-1:0] rf_rs1, rf_rs2;
  logic [DATA_W-1:0] rf_rs1_val = '0, rf_rs2_val = '0;
  logic              rf_write_sig;
  logic [DATA_W-1:0] rf_write_val;
  logic [REG_AW-1:0] rf_write_reg;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_value1, alu_value2;
  logic [DATA_W-1:0] alu_result = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [REG_AW-1:0] rsp_rd;
  logic [DATA_W-1:0] rsp_value;
  logic              rsp_err;
  logic [CNT_W-1:0]  ops_retired;
  logic [2:0]        dbg_state;

  exec_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_use_imm(req_use_imm), .req_imm(req_imm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_write_sig(rf_write_sig), .rf_write_val(rf_write_val), .rf_write_reg(rf_write_reg),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_value(rsp_value), .rsp_err(rsp_err), .ops_retired(ops_retired),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: reg_file + alu ----------------
  logic [DATA_W-1:0] rf_mem [32] = '{default: '0};
  logic              pl_en = 1'b0;
  logic [REG_AW-1:0] pl_idx = '0;
  logic [DATA_W-1:0] pl_val = '0;
  int                wr_pulses = 0;

  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a * b;
      5'd3: return (b == '0) ? '0 : a / b;
      5'd4: return a ^ b;
      5'd5: return a & b;
      5'd6: return a | b;
      5'd7: return (b == '0) ? '0 : a % b;
      5'd8: return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    rf_rs1_val <= rf_mem[rf_rs1];
    rf_rs2_val <= rf_mem[rf_rs2];
    alu_result <= alu_fn(alu_opcode, alu_value1, alu_value2);
    if (pl_en) rf_mem[pl_idx] <= pl_val;
    else if (rf_write_sig && rf_write_reg != '0) rf_mem[rf_write_reg] <= rf_write_val;
    if (rf_write_sig) wr_pulses <= wr_pulses + 1;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] ref_rf [32] = '{default: '0};
  logic [DATA_W-1:0] exp_q[$];
  logic [REG_AW-1:0] exp_rd_q[$];
  logic              exp_err_q[$];
  logic [DATA_W-1:0] wr_val_q[$];
  logic [REG_AW-1:0] wr_reg_q[$];
  logic [CNT_W-1:0]  model_retired = '0;
  logic [DATA_W-1:0] last_rsp_value = '0;
  logic              last_rsp_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result of an op by the instruction-set rules, including the zero-divisor override.
  task automatic model_op(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b,
                          output logic [DATA_W-1:0] r, output logic e);
    r = alu_fn(op, a, b);
    e = 1'b0;
`ifdef DIV_ZERO_GUARD_EN
    if (op == 5'd3 && b == '0) begin r = '1; e = 1'b1; end
    else if (op == 5'd7 && b == '0) begin r = a; e = 1'b1; end
`endif
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_retired <= '0;
    else if (rsp_valid && rsp_ready) model_retired <= model_retired + 1'b1;
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("ops_retired", 64'(ops_retired), 64'(model_retired));
      if (rf_write_sig) begin
        if (wr_val_q.size() == 0) begin
          check("unexpected_write", 64'(rf_write_reg), 64'hFFFF);
        end else begin
          check("wr_reg", 64'(rf_write_reg), 64'(wr_reg_q[0]));
          check("wr_val", rf_write_val, wr_val_q[0]);
          void'(wr_reg_q.pop_front());
          void'(wr_val_q.pop_front());
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_rd), 64'hFFFF);
        end else begin
          check("rsp_value", rsp_value, exp_q[0]);
          check("rsp_rd", 64'(rsp_rd), 64'(exp_rd_q[0]));
          check("rsp_err", 64'(rsp_err), 64'(exp_err_q[0]));
          if (rsp_ready) begin
            last_rsp_value = rsp_value;
            last_rsp_err   = rsp_err;
            void'(exp_q.pop_front());
            void'(exp_rd_q.pop_front());
            void'(exp_err_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [REG_AW-1:0] idx, input logic [DATA_W-1:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_rf[idx] = val;
  endtask

  int last_acc = 0;

  // Issue one op, keep rsp_ready low for 'hold' cycles once rsp_valid rises.
  task automatic do_op(input logic [OP_W-1:0] op, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                       input logic ui, input logic [DATA_W-1:0] imm, input int hold);
    logic [DATA_W-1:0] a, b, r;
    logic e;
    int t;
    a = ref_rf[rs1];
    b = ui ? imm : ref_rf[rs2];
    model_op(op, a, b, r, e);
    exp_q.push_back(r); exp_rd_q.push_back(rd); exp_err_q.push_back(e);
    if (rd != '0) begin
      wr_reg_q.push_back(rd); wr_val_q.push_back(r); ref_rf[rd] = r;
    end
    req_opcode = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_use_imm = ui; req_imm = imm; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    check("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin
      check("req_ready_busy", 64'(req_ready), 64'd0);
      @(posedge clk); #1; t++;
    end
    // rsp_valid rises on the third edge after accept, i.e. in the fourth cycle.
    check("latency", 64'(t), 64'd3);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("req_ready_held", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    check("req_ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int w0, r0, acc1;

  initial begin
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_write", 64'(rf_write_sig), 64'd0);
    check("rst_retired", 64'(ops_retired), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_alu_v1", alu_value1, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: ADD r3 = r1 + r2
    preload(5'd1, 64'd5);
    preload(5'd2, 64'd7);
    do_op(5'd0, 5'd1, 5'd2, 5'd3, 1'b0, 64'd0, 0);
    check("t1_value", last_rsp_value, 64'd12);
    check("t1_r3", rf_mem[3], 64'd12);

    // 2: SUB to rd 0 with immediate: no write
    w0 = wr_pulses;
    do_op(5'd1, 5'd1, 5'd0, 5'd0, 1'b1, 64'd3, 0);
    check("t2_value", last_rsp_value, 64'd2);
    check("t2_no_write", 64'(wr_pulses), 64'(w0));

    // 3: consumer stalls 6 cycles
    w0 = wr_pulses;
    r0 = int'(ops_retired);
    do_op(5'd0, 5'd1, 5'd2, 5'd4, 1'b0, 64'd0, 6);
    check("t3_value", last_rsp_value, 64'd12);
    check("t3_one_write", 64'(wr_pulses), 64'(w0 + 1));
    check("t3_retired", 64'(ops_retired), 64'(r0 + 1));

    // Assorted opcodes
    do_op(5'd2, 5'd1, 5'd2, 5'd10, 1'b0, 64'd0, 1);
    check("mul_value", last_rsp_value, 64'd35);
    do_op(5'd4, 5'd1, 5'd0, 5'd11, 1'b1, 64'hFF, 0);
    check("xor_value", last_rsp_value, 64'hFA);
    do_op(5'd5, 5'd1, 5'd2, 5'd12, 1'b0, 64'd0, 2);
    check("and_value", last_rsp_value, 64'd5);
    do_op(5'd6, 5'd1, 5'd2, 5'd13, 1'b0, 64'd0, 0);
    do_op(5'd8, 5'd1, 5'd0, 5'd14, 1'b0, 64'd0, 0);
    check("not_value", last_rsp_value, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(5'd12, 5'd2, 5'd1, 5'd15, 1'b0, 64'd0, 0);
    check("passthru_value", last_rsp_value, 64'd7);

    // 4: divide / remainder, including zero divisor
    preload(5'd5, 64'd9);
    preload(5'd6, 64'd0);
    do_op(5'd3, 5'd5, 5'd0, 5'd16, 1'b1, 64'd2, 0);
    check("div_value", last_rsp_value, 64'd4);
    do_op(5'd3, 5'd5, 5'd6, 5'd7, 1'b0, 64'd0, 0);
`ifdef DIV_ZERO_GUARD_EN
    check("div0_value", last_rsp_value, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_err", 64'(last_rsp_err), 64'd1);
`else
    check("div0_value", last_rsp_value, 64'd0);
    check("div0_err", 64'(last_rsp_err), 64'd0);
`endif
    do_op(5'd7, 5'd5, 5'd6, 5'd8, 1'b0, 64'd0, 0);
`ifdef DIV_ZERO_GUARD_EN
    check("rem0_value", last_rsp_value, 64'd9);
    check("rem0_err", 64'(last_rsp_err), 64'd1);
    check("rem0_r8", rf_mem[8], 64'd9);
`else
    check("rem0_value", last_rsp_value, 64'd0);
    check("rem0_err", 64'(last_rsp_err), 64'd0);
`endif

    // 6: back-to-back dependent ops
    preload(5'd1, 64'd1);
    do_op(5'd0, 5'd1, 5'd1, 5'd1, 1'b0, 64'd0, 0);
    acc1 = last_acc;
    do_op(5'd0, 5'd1, 5'd1, 5'd2, 1'b0, 64'd0, 0);
    check("t6_value", last_rsp_value, 64'd4);
    check("t6_spacing", 64'(last_acc - acc1), 64'd5);

    // 5: reset during EXEC drops the op
    w0 = wr_pulses;
    req_opcode = 5'd0; req_rs1 = 5'd1; req_rs2 = 5'd1; req_rd = 5'd9;
    req_use_imm = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_in_exec", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    #1;
    check("t5_req_ready", 64'(req_ready), 64'd1);
    check("t5_state", 64'(dbg_state), 64'd0);
    check("t5_write", 64'(rf_write_sig), 64'd0);
    check("t5_retired", 64'(ops_retired), 64'd0);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_write", 64'(wr_pulses), 64'(w0));
    check("t5_r9", rf_mem[9], 64'd0);
    check("t5_idle", 64'(req_ready), 64'd1);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_val_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: a stuck run still reports.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
